// File: rtl/mem_port_arbiter_if.sv
`timescale 1ns/1ps
// mem_port_arbiter_if
//   Bundles the three buses around the shared memory port arbiter:
//   fetch request port (if_*), data request port (dm_*), pipeline stall
//   outputs, and the single-port memory (mem_*).
//   modport slave  : the arbiter itself
//   modport master : the environment (pipeline requesters + memory)
// Parameters: ADDR_W address width, DATA_W data width.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              dm_re;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ready;
  logic              stall_if;
  logic              stall_dm;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_re, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ready, dm_rdata, dm_ready, stall_if, stall_dm,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_re, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ready, dm_rdata, dm_ready, stall_if, stall_dm,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// mem_port_arbiter
//   Shares one single-port, fixed-latency memory between instruction fetch
//   and the MEM stage (loads, stores, call push, return pop). Each access
//   runs IDLE -> ISSUE -> WAIT (reads only) -> DONE -> IDLE. The data port
//   has priority; after STARVE_MAX consecutive data grants with a fetch
//   pending, the fetch is forced through.
// Ports:
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   bus      : mem_port_arbiter_if.slave
//              if_req/if_addr -> if_rdata/if_ready   fetch port
//              dm_re/dm_we/dm_addr/dm_wdata -> dm_rdata/dm_ready  data port
//              stall_if/stall_dm                      combinational stalls
//              mem_en/mem_we/mem_addr/mem_wdata <- mem_rdata  memory port
// Parameters: ADDR_W, DATA_W, MEM_LAT (1..7), STARVE_MAX
// Option macro ARB_IFBUF_EN: one-entry fetch buffer (valid, tag, data);
//   a buffer hit completes the fetch without touching memory.
module mem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);
  localparam int              SC_W       = $clog2(STARVE_MAX + 1);
  localparam logic [2:0]      LAT_INIT   = 3'(MEM_LAT - 1);
  localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t            state;
  logic              gnt_if;
  logic              gnt_wr;
  logic [2:0]        lat_cnt;
  logic [SC_W-1:0]   starve_cnt;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic              if_ready_q;
  logic              dm_ready_q;
  logic              dm_req;
  logic              pick_if;
  logic              buf_hit;
  logic [DATA_W-1:0] buf_rdata;

  function automatic logic [SC_W-1:0] starve_inc(input logic [SC_W-1:0] c);
    return (c == STARVE_LIM) ? c : c + SC_W'(1);
  endfunction

  // Both dm_re and dm_we high is a write; fetch wins only when data is
  // idle or the starvation limit has been reached.
  assign dm_req  = bus.dm_re | bus.dm_we;
  assign pick_if = bus.if_req & (~dm_req | (starve_cnt == STARVE_LIM));

`ifdef ARB_IFBUF_EN
  logic              buf_vld;
  logic [ADDR_W-1:0] buf_tag;
  logic [DATA_W-1:0] buf_data;

  assign buf_hit   = buf_vld && (bus.if_addr == buf_tag);
  assign buf_rdata = buf_data;

  // Stores to the cached address invalidate in their ISSUE cycle; every
  // fetch that completes through memory refills the entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_vld  <= 1'b0;
      buf_tag  <= '0;
      buf_data <= '0;
    end else if (state == ISSUE && gnt_wr && mem_addr_q == buf_tag) begin
      buf_vld <= 1'b0;
    end else if (state == WAIT && lat_cnt == '0 && gnt_if) begin
      buf_vld  <= 1'b1;
      buf_tag  <= mem_addr_q;
      buf_data <= bus.mem_rdata;
    end
  end
`else
  assign buf_hit   = 1'b0;
  assign buf_rdata = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      gnt_if      <= 1'b0;
      gnt_wr      <= 1'b0;
      lat_cnt     <= '0;
      starve_cnt  <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
    end else begin
      if (!bus.if_req) starve_cnt <= '0;
      case (state)
        // Arbitrate and latch the winning request
        IDLE: begin
          if (pick_if || dm_req) begin
            gnt_if     <= pick_if;
            gnt_wr     <= !pick_if && bus.dm_we;
            starve_cnt <= (!pick_if && bus.if_req) ? starve_inc(starve_cnt) : '0;
            if (pick_if && buf_hit) begin
              if_rdata_q <= buf_rdata;
              if_ready_q <= 1'b1;
              state      <= DONE;
            end else begin
              mem_en_q   <= 1'b1;
              mem_we_q   <= !pick_if && bus.dm_we;
              mem_addr_q <= pick_if ? bus.if_addr : bus.dm_addr;
              if (!pick_if && bus.dm_we) mem_wdata_q <= bus.dm_wdata;
              state      <= ISSUE;
            end
          end
        end
        // Memory strobe cycle; writes finish here
        ISSUE: begin
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          if (gnt_wr) begin
            dm_ready_q <= 1'b1;
            state      <= DONE;
          end else begin
            lat_cnt <= LAT_INIT;
            state   <= WAIT;
          end
        end
        // Count down memory latency, capture read data on the last cycle
        WAIT: begin
          if (lat_cnt == '0) begin
            if (gnt_if) begin
              if_rdata_q <= bus.mem_rdata;
              if_ready_q <= 1'b1;
            end else begin
              dm_rdata_q <= bus.mem_rdata;
              dm_ready_q <= 1'b1;
            end
            state <= DONE;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        // One-cycle ready pulse
        default: begin
          if_ready_q <= 1'b0;
          dm_ready_q <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.dm_ready  = dm_ready_q;
  assign bus.stall_if  = bus.if_req & ~if_ready_q;
  assign bus.stall_dm  = dm_req & ~dm_ready_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter with MEM_LAT=2, STARVE_MAX=4.
//   The memory model returns (addr ^ 0xB133) for never-written locations,
//   presents read data only in the single cycle MEM_LAT after mem_en, and
//   0xDEAD otherwise.
module tb_mem_port_arbiter;
  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 16;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Memory model
  logic [DATA_W-1:0] mem [0:255];
  bit   [255:0]      wr_flag;
  logic [DATA_W-1:0] rd_d [MEM_LAT];
  bit                rd_v [MEM_LAT];

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) begin
      mem[bus.mem_addr[7:0]]     <= bus.mem_wdata;
      wr_flag[bus.mem_addr[7:0]] <= 1'b1;
    end
    rd_v[0] <= bus.mem_en && !bus.mem_we;
    rd_d[0] <= wr_flag[bus.mem_addr[7:0]] ? mem[bus.mem_addr[7:0]]
                                          : (bus.mem_addr ^ 16'hB133);
    for (int i = 1; i < MEM_LAT; i++) begin
      rd_v[i] <= rd_v[i-1];
      rd_d[i] <= rd_d[i-1];
    end
  end

  assign bus.mem_rdata = rd_v[MEM_LAT-1] ? rd_d[MEM_LAT-1] : 16'hDEAD;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [ADDR_W-1:0] en_addr [8];
  int n_en;
  int got_if_k;

  initial begin
    rst          = 1'b1;
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.dm_re    = 1'b0;
    bus.dm_we    = 1'b0;
    bus.dm_addr  = '0;
    bus.dm_wdata = '0;
    step(2);

    // Reset state
    chk("rst_mem_en",   bus.mem_en,   0);
    chk("rst_mem_we",   bus.mem_we,   0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_if_ready", bus.if_ready, 0);
    chk("rst_dm_ready", bus.dm_ready, 0);
    chk("rst_if_rdata", bus.if_rdata, 0);
    chk("rst_dm_rdata", bus.dm_rdata, 0);
    rst = 1'b0;
    step(1);

    // 1: fetch only
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0010;
    #1;
    chk("t1_stall_T", bus.stall_if, 1);
    step(1);
    chk("t1_mem_en",   bus.mem_en,   1);
    chk("t1_mem_we",   bus.mem_we,   0);
    chk("t1_mem_addr", bus.mem_addr, 16'h0010);
    step(1);
    chk("t1_mem_en_off", bus.mem_en, 0);
    step(1);
    chk("t1_rdy_T3",   bus.if_ready, 0);
    chk("t1_stall_T3", bus.stall_if, 1);
    step(1);
    chk("t1_rdy_T4",   bus.if_ready, 1);
    chk("t1_rdata",    bus.if_rdata, 16'hB123);
    chk("t1_stall_T4", bus.stall_if, 0);
    bus.if_req = 1'b0;
    step(1);
    chk("t1_rdy_pulse", bus.if_ready, 0);

    // 2: simultaneous fetch and data read, data first
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0030;
    bus.dm_re   = 1'b1;
    bus.dm_addr = 16'h0020;
    #1;
    chk("t2_stall_dm", bus.stall_dm, 1);
    step(1);
    chk("t2_mem_en",   bus.mem_en,   1);
    chk("t2_mem_addr", bus.mem_addr, 16'h0020);
    step(3);
    chk("t2_dm_rdy",   bus.dm_ready, 1);
    chk("t2_dm_rdata", bus.dm_rdata, 16'hB113);
    chk("t2_if_rdy",   bus.if_ready, 0);
    chk("t2_stall_if", bus.stall_if, 1);
    bus.dm_re = 1'b0;
    step(2);
    chk("t2_if_en",    bus.mem_en,   1);
    chk("t2_if_addr",  bus.mem_addr, 16'h0030);
    step(3);
    chk("t2_if_rdy2",  bus.if_ready, 1);
    chk("t2_if_rdata", bus.if_rdata, 16'hB103);
    bus.if_req = 1'b0;
    step(1);

    // 3: data write
    bus.dm_we    = 1'b1;
    bus.dm_addr  = 16'h00FE;
    bus.dm_wdata = 16'h1234;
    step(1);
    chk("t3_mem_en",    bus.mem_en,    1);
    chk("t3_mem_we",    bus.mem_we,    1);
    chk("t3_mem_addr",  bus.mem_addr,  16'h00FE);
    chk("t3_mem_wdata", bus.mem_wdata, 16'h1234);
    step(1);
    chk("t3_dm_rdy",    bus.dm_ready,  1);
    chk("t3_if_rdata",  bus.if_rdata,  16'hB103);
    chk("t3_dm_rdata",  bus.dm_rdata,  16'hB113);
    bus.dm_we = 1'b0;
    step(1);
    chk("t3_rdy_pulse", bus.dm_ready,  0);
    chk("t3_mem_word",  mem[8'hFE],    16'h1234);

    // 4: starvation guard
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0040;
    bus.dm_re   = 1'b1;
    bus.dm_addr = 16'h0050;
    n_en     = 0;
    got_if_k = 0;
    for (int k = 1; k <= 26; k++) begin
      step(1);
      if (bus.mem_en) begin
        if (n_en < 8) en_addr[n_en] = bus.mem_addr;
        n_en++;
      end
      if (k == 20) chk("t4_starve_max", dut.starve_cnt, 4);
      if (k == 21) chk("t4_starve_clr", dut.starve_cnt, 0);
      if (bus.dm_ready) chk("t4_dm_rdata", bus.dm_rdata, 16'hB163);
      if (bus.if_ready) begin
        got_if_k   = k;
        bus.if_req = 1'b0;
        bus.dm_re  = 1'b0;
      end
    end
    chk("t4_n_access", n_en, 5);
    for (int i = 0; i < 4; i++) chk("t4_data_grant", en_addr[i], 16'h0050);
    chk("t4_fetch_grant", en_addr[4],   16'h0040);
    chk("t4_if_rdy_cyc",  got_if_k,     24);
    chk("t4_if_rdata",    bus.if_rdata, 16'hB173);

    // 5: reset during WAIT
    bus.dm_re   = 1'b1;
    bus.dm_addr = 16'h0020;
    step(1);
    chk("t5_mem_en", bus.mem_en, 1);
    step(1);
    rst = 1'b1;
    #1;
    chk("t5_rst_mem_en",   bus.mem_en,   0);
    chk("t5_rst_mem_addr", bus.mem_addr, 0);
    chk("t5_rst_dm_rdata", bus.dm_rdata, 0);
    chk("t5_rst_if_rdata", bus.if_rdata, 0);
    chk("t5_rst_dm_rdy",   bus.dm_ready, 0);
    rst = 1'b0;
    step(1);
    chk("t5_re_mem_en", bus.mem_en,   1);
    chk("t5_no_rdy",    bus.dm_ready, 0);
    step(2);
    chk("t5_no_rdy2",   bus.dm_ready, 0);
    step(1);
    chk("t5_dm_rdy",    bus.dm_ready, 1);
    chk("t5_dm_rdata",  bus.dm_rdata, 16'hB113);
    bus.dm_re = 1'b0;
    step(1);

`ifdef ARB_IFBUF_EN
    // 6: fetch buffer hit and store invalidation
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0010;
    step(4);
    chk("t6_fill_rdy",   bus.if_ready, 1);
    chk("t6_fill_rdata", bus.if_rdata, 16'hB123);
    bus.if_req = 1'b0;
    step(1);
    bus.if_req = 1'b1;
    step(1);
    chk("t6_hit_rdy",    bus.if_ready, 1);
    chk("t6_hit_no_en",  bus.mem_en,   0);
    chk("t6_hit_rdata",  bus.if_rdata, 16'hB123);
    bus.if_req = 1'b0;
    step(1);
    bus.dm_we    = 1'b1;
    bus.dm_addr  = 16'h0010;
    bus.dm_wdata = 16'h5555;
    step(2);
    chk("t6_sw_rdy", bus.dm_ready, 1);
    bus.dm_we = 1'b0;
    step(1);
    bus.if_req = 1'b1;
    step(1);
    chk("t6_miss_en",    bus.mem_en,   1);
    step(3);
    chk("t6_miss_rdy",   bus.if_ready, 1);
    chk("t6_miss_rdata", bus.if_rdata, 16'h5555);
    bus.if_req = 1'b0;
    step(1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
